multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_if.sv | 33 +++
 rtl/multicycle_control_unit.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multicycle control unit and its datapath/memories.
// The control unit connects through the slave modport.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal_instr;
    logic [2:0] state;

    modport master (
        output opcode, imem_ready, dmem_ready, branch_taken,
        input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b,
        input  mem_read, mem_write, reg_write, result_src, illegal_instr, state
    );

    modport slave (
        input  opcode, imem_ready, dmem_ready, branch_taken,
        output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b,
        output mem_read, mem_write, reg_write, result_src, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle RV32I-style datapath.
// Outputs decode from the state and the instruction class latched in DECODE.
module multicycle_control_unit #(
    parameter bit ENABLE_JUMPS    = 1'b1,
    parameter bit ENABLE_UTYPE    = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.slave io_bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsNone, ClsR, ClsIAlu, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc
    } cls_e;

    state_e r_state;
    cls_e   r_cls;
    cls_e   w_dec_cls;

    always_comb begin
        w_dec_cls = ClsNone;
        case (io_bus.opcode)
            7'b0110011: w_dec_cls = ClsR;
            7'b0010011: w_dec_cls = ClsIAlu;
            7'b0000011: w_dec_cls = ClsLoad;
            7'b0100011: w_dec_cls = ClsStore;
            7'b1100011: w_dec_cls = ClsBranch;
            7'b1101111: w_dec_cls = ENABLE_JUMPS ? ClsJal : ClsNone;
            7'b1100111: w_dec_cls = ENABLE_JUMPS ? ClsJalr : ClsNone;
            7'b0110111: w_dec_cls = ENABLE_UTYPE ? ClsLui : ClsNone;
            7'b0010111: w_dec_cls = ENABLE_UTYPE ? ClsAuipc : ClsNone;
            default:    w_dec_cls = ClsNone;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StFetch;
            r_cls   <= ClsNone;
        end else begin
            case (r_state)
                StFetch: begin
                    if (io_bus.imem_ready) r_state <= StDecode;
                end
                StDecode: begin
                    r_cls <= w_dec_cls;
                    if (w_dec_cls == ClsNone) r_state <= HALT_ON_ILLEGAL ? StHalt : StFetch;
                    else                      r_state <= StExec;
                end
                StExec: begin
                    case (r_cls)
                        ClsLoad, ClsStore: r_state <= StMem;
                        ClsBranch, ClsNone: r_state <= StFetch;
                        default:           r_state <= StWb;
                    endcase
                end
                StMem: begin
                    if (io_bus.dmem_ready) r_state <= (r_cls == ClsLoad) ? StWb : StFetch;
                end
                StWb:    r_state <= StFetch;
                StHalt:  r_state <= StHalt;
                default: r_state <= StFetch;
            endcase
        end
    end

    assign io_bus.state = r_state;

    // rst gates every output so reset silences the bus without waiting for an edge.
    always_comb begin
        io_bus.imem_req      = 1'b0;
        io_bus.ir_write      = 1'b0;
        io_bus.pc_write      = 1'b0;
        io_bus.pc_src        = 1'b0;
        io_bus.alu_op        = 2'b00;
        io_bus.alu_src_a     = 2'b00;
        io_bus.alu_src_b     = 2'b00;
        io_bus.mem_read      = 1'b0;
        io_bus.mem_write     = 1'b0;
        io_bus.reg_write     = 1'b0;
        io_bus.result_src    = 2'b00;
        io_bus.illegal_instr = 1'b0;
        if (!rst) begin
            case (r_state)
                StFetch: begin
                    io_bus.imem_req = 1'b1;
                    if (io_bus.imem_ready) begin
                        io_bus.ir_write  = 1'b1;
                        io_bus.pc_write  = 1'b1;
                        io_bus.alu_src_b = 2'b10;
                    end
                end
                StDecode: io_bus.illegal_instr = (w_dec_cls == ClsNone);
                StExec: begin
                    case (r_cls)
                        ClsR: begin
                            io_bus.alu_src_a = 2'b01;
                            io_bus.alu_op    = 2'b10;
                        end
                        ClsIAlu: begin
                            io_bus.alu_src_a = 2'b01;
                            io_bus.alu_src_b = 2'b01;
                            io_bus.alu_op    = 2'b10;
                        end
                        ClsLoad, ClsStore: begin
                            io_bus.alu_src_a = 2'b01;
                            io_bus.alu_src_b = 2'b01;
                        end
                        ClsBranch: begin
                            io_bus.alu_src_a = 2'b01;
                            io_bus.alu_op    = 2'b01;
                            io_bus.pc_src    = 1'b1;
                            io_bus.pc_write  = io_bus.branch_taken;
                        end
                        ClsJal: begin
                            io_bus.pc_write = 1'b1;
                            io_bus.pc_src   = 1'b1;
                        end
                        ClsJalr: begin
                            io_bus.alu_src_a = 2'b01;
                            io_bus.alu_src_b = 2'b01;
                            io_bus.pc_write  = 1'b1;
                        end
                        ClsLui: begin
                            io_bus.alu_src_a = 2'b10;
                            io_bus.alu_src_b = 2'b01;
                        end
                        ClsAuipc: begin
                            io_bus.alu_src_a = 2'b11;
                            io_bus.alu_src_b = 2'b01;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    io_bus.mem_read  = (r_cls == ClsLoad);
                    io_bus.mem_write = (r_cls == ClsStore);
                end
                StWb: begin
                    io_bus.reg_write = 1'b1;
                    if (r_cls == ClsLoad)                           io_bus.result_src = 2'b01;
                    else if (r_cls == ClsJal || r_cls == ClsJalr)   io_bus.result_src = 2'b10;
                end
                StHalt:  io_bus.illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle expected traces built from the instruction rules, applied to
// three parameterisations of the control unit.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic       illegal_instr;
    } out_t;

    typedef struct packed {
        logic       imem_ready;
        logic       dmem_ready;
        logic       branch_taken;
        logic [6:0] opcode;
        out_t       exp;
    } cyc_t;

    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5;
    localparam int K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] opcode = '0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
    int n_tests = 0, n_fail = 0;
    cyc_t q[$];
    cyc_t vec[5];

    always #5 clk = ~clk;

    multicycle_control_unit_if bus_a ();
    multicycle_control_unit_if bus_b ();
    multicycle_control_unit_if bus_c ();

    assign bus_a.opcode = opcode;
    assign bus_a.imem_ready = imem_ready;
    assign bus_a.dmem_ready = dmem_ready;
    assign bus_a.branch_taken = branch_taken;
    assign bus_b.opcode = opcode;
    assign bus_b.imem_ready = imem_ready;
    assign bus_b.dmem_ready = dmem_ready;
    assign bus_b.branch_taken = branch_taken;
    assign bus_c.opcode = opcode;
    assign bus_c.imem_ready = imem_ready;
    assign bus_c.dmem_ready = dmem_ready;
    assign bus_c.branch_taken = branch_taken;

    multicycle_control_unit #(
        .ENABLE_JUMPS(1'b1), .ENABLE_UTYPE(1'b1), .HALT_ON_ILLEGAL(1'b1)
    ) u_dut_a (.clk(clk), .rst(rst), .io_bus(bus_a));

    multicycle_control_unit #(
        .ENABLE_JUMPS(1'b0), .ENABLE_UTYPE(1'b0), .HALT_ON_ILLEGAL(1'b1)
    ) u_dut_b (.clk(clk), .rst(rst), .io_bus(bus_b));

    multicycle_control_unit #(
        .ENABLE_JUMPS(1'b0), .ENABLE_UTYPE(1'b1), .HALT_ON_ILLEGAL(1'b0)
    ) u_dut_c (.clk(clk), .rst(rst), .io_bus(bus_c));

    function automatic out_t sample(input int w);
        out_t o;
        case (w)
            0: o = {bus_a.state, bus_a.imem_req, bus_a.ir_write, bus_a.pc_write, bus_a.pc_src,
                    bus_a.alu_op, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.mem_read,
                    bus_a.mem_write, bus_a.reg_write, bus_a.result_src, bus_a.illegal_instr};
            1: o = {bus_b.state, bus_b.imem_req, bus_b.ir_write, bus_b.pc_write, bus_b.pc_src,
                    bus_b.alu_op, bus_b.alu_src_a, bus_b.alu_src_b, bus_b.mem_read,
                    bus_b.mem_write, bus_b.reg_write, bus_b.result_src, bus_b.illegal_instr};
            default: o = {bus_c.state, bus_c.imem_req, bus_c.ir_write, bus_c.pc_write,
                    bus_c.pc_src, bus_c.alu_op, bus_c.alu_src_a, bus_c.alu_src_b,
                    bus_c.mem_read, bus_c.mem_write, bus_c.reg_write, bus_c.result_src,
                    bus_c.illegal_instr};
        endcase
        return o;
    endfunction

    function automatic int kind_of(input logic [6:0] op, input bit jmp, input bit ut);
        if (op == OP_R) return K_R;
        if (op == OP_I) return K_I;
        if (op == OP_LD) return K_LOAD;
        if (op == OP_ST) return K_STORE;
        if (op == OP_BR) return K_BR;
        if (op == OP_JAL) return jmp ? K_JAL : K_ILL;
        if (op == OP_JALR) return jmp ? K_JALR : K_ILL;
        if (op == OP_LUI) return ut ? K_LUI : K_ILL;
        if (op == OP_AUIPC) return ut ? K_AUIPC : K_ILL;
        return K_ILL;
    endfunction

    task automatic check(input string name, input int idx, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b (state got %0d exp %0d)",
                     name, idx, got, exp, got.state, exp.state);
        end
    endtask

    // Expected per-cycle trace of one instruction; opcode is only valid during DECODE.
    task automatic plan(input logic [6:0] op, input int iw, input int dw, input bit bt,
                        input bit jmp, input bit ut, input bit hlt, input int hc);
        cyc_t c;
        int k;
        logic [6:0] noise;
        k = kind_of(op, jmp, ut);
        noise = op ^ 7'h20;
        c = '0;
        c.opcode = noise;
        c.dmem_ready = 1'b1;
        c.branch_taken = bt;
        c.exp.imem_req = 1'b1;
        for (int i = 0; i < iw; i++) q.push_back(c);
        c.imem_ready = 1'b1;
        c.exp.ir_write = 1'b1;
        c.exp.pc_write = 1'b1;
        c.exp.alu_src_b = 2'b10;
        q.push_back(c);
        c.exp = '0;
        c.exp.state = 3'd1;
        c.opcode = op;
        c.exp.illegal_instr = (k == K_ILL);
        q.push_back(c);
        c.opcode = noise;
        if (k == K_ILL) begin
            if (hlt) begin
                c.exp = '0;
                c.exp.state = 3'd5;
                c.exp.illegal_instr = 1'b1;
                for (int i = 0; i < hc; i++) q.push_back(c);
            end
            return;
        end
        c.exp = '0;
        c.exp.state = 3'd2;
        case (k)
            K_R:     begin c.exp.alu_src_a = 2'b01; c.exp.alu_op = 2'b10; end
            K_I:     begin c.exp.alu_src_a = 2'b01; c.exp.alu_src_b = 2'b01;
                           c.exp.alu_op = 2'b10; end
            K_LOAD, K_STORE: begin c.exp.alu_src_a = 2'b01; c.exp.alu_src_b = 2'b01; end
            K_BR:    begin c.exp.alu_src_a = 2'b01; c.exp.alu_op = 2'b01; c.exp.pc_src = 1'b1;
                           c.exp.pc_write = bt; end
            K_JAL:   begin c.exp.pc_write = 1'b1; c.exp.pc_src = 1'b1; end
            K_JALR:  begin c.exp.alu_src_a = 2'b01; c.exp.alu_src_b = 2'b01;
                           c.exp.pc_write = 1'b1; end
            K_LUI:   begin c.exp.alu_src_a = 2'b10; c.exp.alu_src_b = 2'b01; end
            default: begin c.exp.alu_src_a = 2'b11; c.exp.alu_src_b = 2'b01; end
        endcase
        q.push_back(c);
        if (k == K_LOAD || k == K_STORE) begin
            c.exp = '0;
            c.exp.state = 3'd3;
            c.exp.mem_read = (k == K_LOAD);
            c.exp.mem_write = (k == K_STORE);
            c.dmem_ready = 1'b0;
            for (int i = 0; i < dw; i++) q.push_back(c);
            c.dmem_ready = 1'b1;
            q.push_back(c);
        end
        if (k != K_STORE && k != K_BR) begin
            c.exp = '0;
            c.exp.state = 3'd4;
            c.exp.reg_write = 1'b1;
            if (k == K_LOAD) c.exp.result_src = 2'b01;
            else if (k == K_JAL || k == K_JALR) c.exp.result_src = 2'b10;
            q.push_back(c);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic run_q(input string name, input int w, input int n);
        int lim;
        lim = (n < 0) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            opcode = q[i].opcode;
            imem_ready = q[i].imem_ready;
            dmem_ready = q[i].dmem_ready;
            branch_taken = q[i].branch_taken;
            #1;
            check(name, i, sample(w), q[i].exp);
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b1;
        #1;
        check("reset_a", 0, sample(0), '0);
        check("reset_b", 0, sample(1), '0);
        check("reset_c", 0, sample(2), '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal [9];
        out_t mw;
        legal = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        // R-type reference trace: FETCH, DECODE, EXEC, WB, FETCH.
        vec[0] = {1'b1, 1'b0, 1'b0, OP_ST,
                  19'({3'd0, 4'b1110, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0})};
        vec[1] = {1'b0, 1'b0, 1'b0, OP_R,
                  19'({3'd1, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0})};
        vec[2] = {1'b0, 1'b0, 1'b0, OP_ST,
                  19'({3'd2, 4'b0000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0})};
        vec[3] = {1'b0, 1'b0, 1'b0, OP_ST,
                  19'({3'd4, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0})};
        vec[4] = {1'b0, 1'b0, 1'b0, OP_ST,
                  19'({3'd0, 4'b1000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0})};

        do_reset();
        for (int i = 0; i < 5; i++) q.push_back(vec[i]);
        run_q("rtype_table", 0, -1);

        plan(OP_LD, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_q("load_wait3", 0, -1);
        plan(OP_BR, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        run_q("branch_taken", 0, -1);
        plan(OP_BR, 1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_q("branch_not_taken", 0, -1);
        plan(OP_LD, 0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_q("load_opcode_swap", 0, -1);

        do_reset();
        plan(OP_JAL, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        run_q("jal_disabled_halt", 1, -1);
        do_reset();
        plan(OP_LUI, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        run_q("lui_disabled_halt", 1, -1);
        do_reset();
        plan(OP_JAL, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        plan(OP_AUIPC, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_q("jal_disabled_skip", 2, -1);

        // Reset while a store waits in MEM.
        do_reset();
        plan(OP_ST, 1, 5, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_q("store_pre_abort", 0, 5);
        dmem_ready = 1'b0;
        #1;
        mw = '0;
        mw.state = 3'd3;
        mw.mem_write = 1'b1;
        check("store_waiting", 0, sample(0), mw);
        #1 rst = 1'b1;
        #1;
        check("store_async_abort", 0, sample(0), '0);
        @(negedge clk);
        rst = 1'b0;
        plan(OP_R, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_q("resume_after_abort", 0, -1);

        do_reset();
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            int r;
            r = $urandom_range(0, 11);
            op = (r < 9) ? legal[r] : 7'($urandom);
            plan(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 1'b1, 1'b1,
                 1'b1, 3);
            run_q("random", 0, -1);
            if (kind_of(op, 1'b1, 1'b1) == K_ILL) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
